// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stage bit map, FSM states
// and the per-event hold/flush masks.
package pipe_hazard_ctrl_pkg;

    localparam int DEF_WORD_WIDTH = 32;
    localparam int PIPE_STAGES    = 4;

    // Stage bit indices used by every stage vector
    localparam int IFID  = 0;
    localparam int IDEX  = 1;
    localparam int EXMEM = 2;
    localparam int MEMWB = 3;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        EXEC = 2'd1,
        IRQ  = 2'd2
    } state_e;

    typedef logic [PIPE_STAGES-1:0] stage_vec_t;

    function automatic stage_vec_t stage_bit(input int idx);
        stage_vec_t v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    localparam stage_vec_t STALL_HOLD  = stage_bit(IFID) | stage_bit(IDEX) | stage_bit(EXMEM);
    localparam stage_vec_t STALL_FLUSH = stage_bit(MEMWB);
    localparam stage_vec_t IRQ_FLUSH   = stage_bit(IFID) | stage_bit(IDEX) | stage_bit(EXMEM);
    localparam stage_vec_t JUMP_FLUSH  = stage_bit(IFID) | stage_bit(IDEX);
    localparam stage_vec_t EXEC_HOLD   = stage_bit(IFID) | stage_bit(IDEX);
    localparam stage_vec_t EXEC_FLUSH  = stage_bit(EXMEM);
    localparam stage_vec_t LU_HOLD     = stage_bit(IFID);
    localparam stage_vec_t LU_FLUSH    = stage_bit(IDEX);

endpackage

// File: rtl/pipe_hazard_ctrl_exec_cycle_cnt.sv
// Loadable down-counter that times fixed-latency EX operations.
// Saturates at zero; load wins over decrement.
module pipe_hazard_ctrl_exec_cycle_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: arbitrates mem stalls, interrupts, jumps,
// multi-cycle EX ops and load-use bubbles into per-stage hold/flush and PC control.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
    parameter int EXEC_CYCLES = 33
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   jump_req,
    input  logic [WORD_WIDTH-1:0]  jump_addr,
    input  logic                   load_use,
    input  logic                   exec_start,
    input  logic                   mem_req,
    input  logic                   mem_ack,
    input  logic                   irq_req,
    input  logic [WORD_WIDTH-1:0]  irq_vector,
    output logic                   pc_hold,
    output logic                   pc_jump,
    output logic [WORD_WIDTH-1:0]  pc_jump_addr,
    output logic [PIPE_STAGES-1:0] hold_flag,
    output logic [PIPE_STAGES-1:0] flush_flag,
    output logic                   exec_done,
    output logic                   irq_ack
);

    localparam int CNT_W = $clog2(EXEC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 2);

    state_e                  state_q;
    state_e                  state_d;
    logic [WORD_WIDTH-1:0]   irq_vector_q;
    logic [WORD_WIDTH-1:0]   irq_vector_d;
    logic                    mem_stall;
    logic                    cnt_load;
    logic                    cnt_zero;
    stage_vec_t              hold_raw;
    stage_vec_t              flush_raw;

    assign mem_stall = mem_req & ~mem_ack;

    pipe_hazard_ctrl_exec_cycle_cnt #(
        .CNT_W(CNT_W)
    ) u_exec_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (CNT_LOAD),
        .en       (state_q == EXEC),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            irq_vector_q <= '0;
        end else begin
            state_q      <= state_d;
            irq_vector_q <= irq_vector_d;
        end
    end

    // Next state: a stall freezes RUN and IRQ, but the EX countdown keeps running.
    always_comb begin
        state_d      = state_q;
        irq_vector_d = irq_vector_q;
        cnt_load     = 1'b0;
        case (state_q)
            RUN: begin
                if (!mem_stall && !jump_req) begin
                    if (exec_start) begin
                        state_d  = EXEC;
                        cnt_load = 1'b1;
                    end else if (!load_use && irq_req) begin
                        state_d      = IRQ;
                        irq_vector_d = irq_vector;
                    end
                end
            end
            EXEC: begin
                if (cnt_zero) begin
                    state_d = RUN;
                end
            end
            IRQ: begin
                if (!mem_stall) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_hold      = 1'b0;
        pc_jump      = 1'b0;
        pc_jump_addr = '0;
        hold_raw     = '0;
        flush_raw    = '0;
        irq_ack      = 1'b0;
        if (rst_n) begin
            if (mem_stall) begin
                pc_hold   = 1'b1;
                hold_raw  = STALL_HOLD;
                flush_raw = STALL_FLUSH;
            end else begin
                case (state_q)
                    IRQ: begin
                        pc_jump      = 1'b1;
                        pc_jump_addr = irq_vector_q;
                        flush_raw    = IRQ_FLUSH;
                        irq_ack      = 1'b1;
                    end
                    EXEC: begin
                        pc_hold   = 1'b1;
                        hold_raw  = EXEC_HOLD;
                        flush_raw = EXEC_FLUSH;
                    end
                    RUN: begin
                        if (jump_req) begin
                            pc_jump      = 1'b1;
                            pc_jump_addr = jump_addr;
                            flush_raw    = JUMP_FLUSH;
                        end else if (!exec_start && load_use) begin
                            pc_hold   = 1'b1;
                            hold_raw  = LU_HOLD;
                            flush_raw = LU_FLUSH;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign exec_done = rst_n & (state_q == EXEC) & cnt_zero;

    // Flush overrides hold per stage so a stage never sees both
    for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
        assign flush_flag[gi] = flush_raw[gi];
        assign hold_flag[gi]  = hold_raw[gi] & ~flush_raw[gi];
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with EXEC_CYCLES=4; expected outputs are
// queued when each step is driven and compared at the falling edge.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic        pc_hold;
        logic        pc_jump;
        logic [31:0] addr;
        logic [3:0]  hold;
        logic [3:0]  flush;
        logic        exec_done;
        logic        irq_ack;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump_req;
    logic [31:0] jump_addr;
    logic        load_use;
    logic        exec_start;
    logic        mem_req;
    logic        mem_ack;
    logic        irq_req;
    logic [31:0] irq_vector;
    logic        pc_hold;
    logic        pc_jump;
    logic [31:0] pc_jump_addr;
    logic [3:0]  hold_flag;
    logic [3:0]  flush_flag;
    logic        exec_done;
    logic        irq_ack;

    int checks = 0;
    int errors = 0;
    obs_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .WORD_WIDTH (32),
        .EXEC_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .jump_req    (jump_req),
        .jump_addr   (jump_addr),
        .load_use    (load_use),
        .exec_start  (exec_start),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .irq_req     (irq_req),
        .irq_vector  (irq_vector),
        .pc_hold     (pc_hold),
        .pc_jump     (pc_jump),
        .pc_jump_addr(pc_jump_addr),
        .hold_flag   (hold_flag),
        .flush_flag  (flush_flag),
        .exec_done   (exec_done),
        .irq_ack     (irq_ack)
    );

    function automatic obs_t mk(input logic ph, input logic pj, input logic [31:0] a,
                                input logic [3:0] h, input logic [3:0] f,
                                input logic d, input logic k);
        obs_t o;
        o.pc_hold   = ph;
        o.pc_jump   = pj;
        o.addr      = a;
        o.hold      = h;
        o.flush     = f;
        o.exec_done = d;
        o.irq_ack   = k;
        return o;
    endfunction

    function automatic obs_t z_o();
        return mk(1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    endfunction
    function automatic obs_t lu_o();
        return mk(1'b1, 1'b0, 32'h0, 4'b0001, 4'b0010, 1'b0, 1'b0);
    endfunction
    function automatic obs_t ex_o(input logic done);
        return mk(1'b1, 1'b0, 32'h0, 4'b0011, 4'b0100, done, 1'b0);
    endfunction
    function automatic obs_t st_o(input logic done);
        return mk(1'b1, 1'b0, 32'h0, 4'b0111, 4'b1000, done, 1'b0);
    endfunction
    function automatic obs_t jp_o(input logic [31:0] a);
        return mk(1'b0, 1'b1, a, 4'b0000, 4'b0011, 1'b0, 1'b0);
    endfunction
    function automatic obs_t iq_o(input logic [31:0] a);
        return mk(1'b0, 1'b1, a, 4'b0000, 4'b0111, 1'b0, 1'b1);
    endfunction

    task automatic idle();
        jump_req   = 1'b0;
        jump_addr  = 32'h0;
        load_use   = 1'b0;
        exec_start = 1'b0;
        mem_req    = 1'b0;
        mem_ack    = 1'b0;
        irq_req    = 1'b0;
        irq_vector = 32'h0;
    endtask

    // Inputs are already applied; queue the expectation, compare mid-cycle, advance.
    task automatic step(input string tag, input obs_t e);
        obs_t  o;
        obs_t  ex;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        o  = mk(pc_hold, pc_jump, pc_jump_addr, hold_flag, flush_flag, exec_done, irq_ack);
        ex = exp_q.pop_front();
        t  = tag_q.pop_front();
        if (!ex.pc_jump) begin
            o.addr  = 32'h0;
            ex.addr = 32'h0;
        end
        checks++;
        assert (o === ex) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, o, ex);
        end
        $display("step %-16s observed=%h", t, o);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        jump_req = 1'b1; jump_addr = 32'h0000_0100; load_use = 1'b1; mem_req = 1'b1;
        step("reset_forced0", z_o());
        rst_n = 1'b1;
        idle();
        step("idle", z_o());

        // load-use bubble for one cycle only
        load_use = 1'b1;
        step("load_use", lu_o());
        load_use = 1'b0;
        step("load_use_after", z_o());

        // jump wins over load_use and irq
        jump_req = 1'b1; jump_addr = 32'h0000_0100; load_use = 1'b1; irq_req = 1'b1;
        irq_vector = 32'hAAAA_0000;
        step("jump", jp_o(32'h0000_0100));
        idle();
        step("jump_after", z_o());

        // multi-cycle op, exec_start held through EXEC
        exec_start = 1'b1; load_use = 1'b1;
        step("exec_c1_issue", z_o());
        step("exec_c2", ex_o(1'b0));
        step("exec_c3", ex_o(1'b0));
        step("exec_c4_done", ex_o(1'b1));
        idle();
        step("exec_c5_run", z_o());

        // mem stall with pending jump
        mem_req = 1'b1; jump_req = 1'b1; jump_addr = 32'h0000_0200;
        step("stall_1", st_o(1'b0));
        step("stall_2", st_o(1'b0));
        step("stall_3", st_o(1'b0));
        mem_ack = 1'b1;
        step("stall_ack_jump", jp_o(32'h0000_0200));
        idle();
        step("stall_after", z_o());

        // stall inside EXEC: countdown continues
        exec_start = 1'b1;
        step("exs_c1_issue", z_o());
        mem_req = 1'b1;
        step("exs_c2_stall", st_o(1'b0));
        mem_req = 1'b0;
        step("exs_c3", ex_o(1'b0));
        mem_req = 1'b1;
        step("exs_c4_stall_done", st_o(1'b1));
        idle();
        step("exs_c5_run", z_o());

        // irq pending across EXEC, accepted on first RUN cycle
        exec_start = 1'b1; irq_req = 1'b1; irq_vector = 32'hDEAD_BEEF;
        step("irq_c1_issue", z_o());
        step("irq_c2_exec", ex_o(1'b0));
        step("irq_c3_exec", ex_o(1'b0));
        step("irq_c4_done", ex_o(1'b1));
        exec_start = 1'b0;
        step("irq_accept", z_o());
        irq_vector = 32'h1234_5678;
        step("irq_ack", iq_o(32'hDEAD_BEEF));
        idle();
        step("irq_after", z_o());

        // load_use blocks accept; IRQ state waits out a stall
        irq_req = 1'b1; irq_vector = 32'h0000_0800; load_use = 1'b1;
        step("irq_lu_block", lu_o());
        load_use = 1'b0;
        step("irq_accept2", z_o());
        irq_vector = 32'h0;
        mem_req = 1'b1;
        step("irq_state_stall", st_o(1'b0));
        mem_req = 1'b0;
        step("irq_ack2", iq_o(32'h0000_0800));
        idle();
        step("irq_after2", z_o());

        // async reset mid-EXEC
        exec_start = 1'b1;
        step("rst_c1_issue", z_o());
        step("rst_c2_exec", ex_o(1'b0));
        rst_n = 1'b0; load_use = 1'b1;
        step("rst_low", z_o());
        rst_n = 1'b1;
        idle();
        step("rst_post_1", z_o());
        step("rst_post_2", z_o());
        load_use = 1'b1;
        step("rst_post_lu", lu_o());
        idle();
        step("final_idle", z_o());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
